riscv_test_monitor: RTL and testbench

Synthesizable end-of-test monitor for riscv-tests runs on the core. It watches the core's PC, the `gp` (x3) register and data-memory stores, and classifies each run as passed, failed (with test number), timed out or hung. It generalises the per-test simulation harness check (fixed done-PC, fixed tick budget, `gp == 1`) into one parametrised block. The bench instantiates it beside `Core` and writes the result file from its outputs.

---
 rtl/riscv_test_monitor.sv | 128 ++++++++++++
 tb/tb_riscv_test_monitor.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_test_monitor.sv
// End-of-test monitor for riscv-tests: classifies a run as pass, fail (with test number), timeout or hang.
// Watches PC, gp and tohost stores. Outputs are registered, one cycle after the qualifying sample, and are sticky.
module riscv_test_monitor #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] DONE_PC     = 'h44,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 'h1000,
  parameter int unsigned     MODE        = 0,
  parameter int unsigned     TIMEOUT     = 5000,
  parameter int unsigned     HANG_LIMIT  = 64,
  parameter int unsigned     CNT_W       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] gp,
  input  logic            mem_we,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic            timeout,
  output logic            hang,
  output logic [XLEN-2:0] fail_num,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [2:0] {
    S_RESET,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT,
    S_HANG
  } state_t;

  localparam bit               PC_EN     = (MODE == 0) || (MODE == 2);
  localparam bit               TH_EN     = (MODE == 1) || (MODE == 2);
  localparam bit               HANG_EN   = (HANG_LIMIT > 0);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [31:0]      HANG_LAST = HANG_EN ? 32'(HANG_LIMIT - 1) : 32'd0;
  localparam logic [31:0]      STALL_MAX = '1;
  localparam logic [XLEN-1:0]  END_PASS  = {{(XLEN-1){1'b0}}, 1'b1};

  state_t            state_q;
  logic [XLEN-1:0]   prev_pc_q;
  logic [31:0]       stall_q, stall_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic              done_q, pass_q, fail_q, timeout_q, hang_q;
  logic [XLEN-2:0]   fail_num_q;

  logic              pc_evt, th_evt, end_evt, pc_same, hang_evt, timeout_evt;
  logic [XLEN-1:0]   end_val;

  always_comb begin
    pc_evt      = PC_EN && (pc == DONE_PC);
    th_evt      = TH_EN && mem_we && (mem_addr == TOHOST_ADDR);
    end_evt     = pc_evt || th_evt;
    // A simultaneous tohost store carries the more specific verdict, so it wins.
    end_val     = th_evt ? mem_wdata : gp;
    pc_same     = (pc == prev_pc_q);
    hang_evt    = HANG_EN && pc_same && (stall_q == HANG_LAST);
    timeout_evt = (cycles_q == TO_LAST);
  end

  always_comb begin
    stall_d = 32'd0;
    if (HANG_EN && pc_same) begin
      stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + 32'd1;
    end
    cycles_d = (cycles_q == CNT_MAX) ? cycles_q : cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RESET;
      prev_pc_q  <= '0;
      stall_q    <= '0;
      cycles_q   <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      hang_q     <= 1'b0;
      fail_num_q <= '0;
    end else begin
      case (state_q)
        S_RESET: state_q <= S_RUN;
        S_RUN: begin
          prev_pc_q <= pc;
          stall_q   <= stall_d;
          if (end_evt) begin
            done_q <= 1'b1;
            if (end_val == END_PASS) begin
              state_q <= S_PASS;
              pass_q  <= 1'b1;
            end else begin
              state_q    <= S_FAIL;
              fail_q     <= 1'b1;
              fail_num_q <= end_val[XLEN-1:1];
            end
          end else if (hang_evt) begin
            state_q <= S_HANG;
            done_q  <= 1'b1;
            hang_q  <= 1'b1;
          end else if (timeout_evt) begin
            state_q   <= S_TIMEOUT;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            cycles_q <= cycles_d;
          end
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign timeout  = timeout_q;
  assign hang     = hang_q;
  assign fail_num = fail_num_q;
  assign cycles   = cycles_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor: five instances with different modes/limits share one stimulus stream.
module tb_riscv_test_monitor;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0, gp = '0, mem_addr = '0, mem_wdata = '0;
  logic        mem_we = 1'b0;

  // 0: MODE0 default, 1: MODE1, 2: TIMEOUT=20 no hang, 3: HANG_LIMIT=8, 4: MODE2
  logic        done_w[5], pass_w[5], fail_w[5], to_w[5], hang_w[5];
  logic [30:0] fn_w[5];
  logic [31:0] cy_w[5];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  riscv_test_monitor #(.MODE(0)) u0 (.clk(clk), .rst(rst), .pc(pc), .gp(gp), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done_w[0]), .pass(pass_w[0]), .fail(fail_w[0]),
    .timeout(to_w[0]), .hang(hang_w[0]), .fail_num(fn_w[0]), .cycles(cy_w[0]));
  riscv_test_monitor #(.MODE(1)) u1 (.clk(clk), .rst(rst), .pc(pc), .gp(gp), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done_w[1]), .pass(pass_w[1]), .fail(fail_w[1]),
    .timeout(to_w[1]), .hang(hang_w[1]), .fail_num(fn_w[1]), .cycles(cy_w[1]));
  riscv_test_monitor #(.MODE(0), .TIMEOUT(20), .HANG_LIMIT(0)) u2 (.clk(clk), .rst(rst), .pc(pc), .gp(gp),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done_w[2]), .pass(pass_w[2]),
    .fail(fail_w[2]), .timeout(to_w[2]), .hang(hang_w[2]), .fail_num(fn_w[2]), .cycles(cy_w[2]));
  riscv_test_monitor #(.MODE(0), .HANG_LIMIT(8)) u3 (.clk(clk), .rst(rst), .pc(pc), .gp(gp), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done_w[3]), .pass(pass_w[3]), .fail(fail_w[3]),
    .timeout(to_w[3]), .hang(hang_w[3]), .fail_num(fn_w[3]), .cycles(cy_w[3]));
  riscv_test_monitor #(.MODE(2)) u4 (.clk(clk), .rst(rst), .pc(pc), .gp(gp), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done_w[4]), .pass(pass_w[4]), .fail(fail_w[4]),
    .timeout(to_w[4]), .hang(hang_w[4]), .fail_num(fn_w[4]), .cycles(cy_w[4]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the monitors in their first RUN cycle, 1 time unit after the RESET->RUN edge.
  task automatic do_reset();
    rst = 1'b1; pc = '0; gp = '0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_checks++; if ({done_w[0], pass_w[0], fail_w[0], to_w[0], hang_w[0]} !== 5'b0) begin n_fail++;
      $display("FAIL reset_flags got=%b exp=00000", {done_w[0], pass_w[0], fail_w[0], to_w[0], hang_w[0]}); end
    n_checks++; if (fn_w[0] !== 31'd0) begin n_fail++; $display("FAIL reset_fail_num got=%0d exp=0", fn_w[0]); end
    do_reset();
    n_checks++; if (cy_w[0] !== 32'd0) begin n_fail++; $display("FAIL run_entry_cycles got=%0d exp=0", cy_w[0]); end
    n_checks++; if (done_w[0] !== 1'b0) begin n_fail++; $display("FAIL run_entry_done got=%b exp=0", done_w[0]); end
  endtask

  task automatic test_mode0_pass();
    do_reset();
    for (int i = 0; i < 17; i++) begin pc = 32'(i * 4); gp = 32'd0; tick(); end
    n_checks++; if (pass_w[0] !== 1'b0 || cy_w[0] !== 32'd17) begin n_fail++;
      $display("FAIL m0_pre_match pass=%b cycles=%0d exp pass=0 cycles=17", pass_w[0], cy_w[0]); end
    pc = 32'h44; gp = 32'd1; tick();
    n_checks++; if ({pass_w[0], done_w[0], fail_w[0]} !== 3'b110) begin n_fail++;
      $display("FAIL m0_pass pass,done,fail=%b exp=110", {pass_w[0], done_w[0], fail_w[0]}); end
    n_checks++; if (cy_w[0] !== 32'd17) begin n_fail++; $display("FAIL m0_pass_cycles got=%0d exp=17", cy_w[0]); end
    pc = 32'h48; gp = 32'd9; tick(); tick();
    n_checks++; if (pass_w[0] !== 1'b1 || cy_w[0] !== 32'd17) begin n_fail++;
      $display("FAIL m0_sticky pass=%b cycles=%0d exp pass=1 cycles=17", pass_w[0], cy_w[0]); end
  endtask

  task automatic test_mode0_fail();
    do_reset();
    for (int i = 0; i < 17; i++) begin pc = 32'(i * 4); gp = 32'd0; tick(); end
    pc = 32'h44; gp = 32'h7; tick();
    n_checks++; if ({fail_w[0], pass_w[0], done_w[0]} !== 3'b101) begin n_fail++;
      $display("FAIL m0_fail fail,pass,done=%b exp=101", {fail_w[0], pass_w[0], done_w[0]}); end
    n_checks++; if (fn_w[0] !== 31'd3) begin n_fail++; $display("FAIL m0_fail_num got=%0d exp=3", fn_w[0]); end
  endtask

  task automatic test_tohost();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pc = 32'h200 + 32'(i * 4); mem_we = 1'b1; mem_addr = 32'h1004; mem_wdata = 32'd1; tick();
    end
    n_checks++; if (done_w[1] !== 1'b0) begin n_fail++; $display("FAIL th_wrong_addr done=%b exp=0", done_w[1]); end
    pc = 32'h20c; mem_addr = 32'h1000; mem_wdata = 32'd1; tick();
    n_checks++; if ({pass_w[1], fail_w[1], done_w[1]} !== 3'b101 || cy_w[1] !== 32'd3) begin n_fail++;
      $display("FAIL th_pass pass,fail,done=%b cycles=%0d exp=101 cycles=3",
               {pass_w[1], fail_w[1], done_w[1]}, cy_w[1]); end
    mem_wdata = 32'h15; pc = 32'h210; tick(); tick();
    n_checks++; if ({pass_w[1], fail_w[1]} !== 2'b10) begin n_fail++;
      $display("FAIL th_terminal_ignore pass,fail=%b exp=10", {pass_w[1], fail_w[1]}); end
    do_reset();
    pc = 32'h200; mem_we = 1'b0; tick();
    pc = 32'h204; mem_we = 1'b1; mem_addr = 32'h1000; mem_wdata = 32'h15; tick();
    n_checks++; if ({fail_w[1], pass_w[1]} !== 2'b10 || fn_w[1] !== 31'd10) begin n_fail++;
      $display("FAIL th_fail fail,pass=%b fail_num=%0d exp=10 fail_num=10", {fail_w[1], pass_w[1]}, fn_w[1]); end
    mem_we = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 19; i++) begin pc = 32'h300 + 32'(i * 4); tick(); end
    n_checks++; if (to_w[2] !== 1'b0 || cy_w[2] !== 32'd19) begin n_fail++;
      $display("FAIL to_edge19 timeout=%b cycles=%0d exp timeout=0 cycles=19", to_w[2], cy_w[2]); end
    pc = 32'h34c; tick();
    n_checks++; if ({to_w[2], done_w[2], pass_w[2], fail_w[2], hang_w[2]} !== 5'b11000) begin n_fail++;
      $display("FAIL to_edge20 timeout,done,pass,fail,hang=%b exp=11000",
               {to_w[2], done_w[2], pass_w[2], fail_w[2], hang_w[2]}); end
    for (int i = 0; i < 5; i++) begin pc = 32'h350 + 32'(i * 4); tick(); end
    n_checks++; if (cy_w[2] !== 32'd19 || to_w[2] !== 1'b1) begin n_fail++;
      $display("FAIL to_frozen cycles=%0d timeout=%b exp cycles=19 timeout=1", cy_w[2], to_w[2]); end
  endtask

  task automatic test_hang();
    do_reset();
    pc = 32'h100;
    // First RUN sample compares against the reset previous-PC of 0; repeats start on the second edge.
    for (int i = 0; i < 8; i++) tick();
    n_checks++; if (hang_w[3] !== 1'b0) begin n_fail++; $display("FAIL hang_early hang=%b exp=0", hang_w[3]); end
    tick();
    n_checks++; if ({hang_w[3], done_w[3], pass_w[3], to_w[3]} !== 4'b1100) begin n_fail++;
      $display("FAIL hang_rise hang,done,pass,timeout=%b exp=1100", {hang_w[3], done_w[3], pass_w[3], to_w[3]}); end
    n_checks++; if (hang_w[0] !== 1'b0) begin n_fail++; $display("FAIL hang_limit64 hang=%b exp=0", hang_w[0]); end
    do_reset();
    pc = 32'h44; gp = 32'd1;
    for (int i = 0; i < 12; i++) tick();
    n_checks++; if ({pass_w[3], hang_w[3]} !== 2'b10) begin n_fail++;
      $display("FAIL hang_prio pass,hang=%b exp=10", {pass_w[3], hang_w[3]}); end
  endtask

  task automatic test_mode2();
    do_reset();
    pc = 32'h10; tick();
    pc = 32'h44; gp = 32'd1; mem_we = 1'b1; mem_addr = 32'h1000; mem_wdata = 32'd5; tick();
    n_checks++; if ({fail_w[4], pass_w[4]} !== 2'b10 || fn_w[4] !== 31'd2) begin n_fail++;
      $display("FAIL m2_both fail,pass=%b fail_num=%0d exp=10 fail_num=2", {fail_w[4], pass_w[4]}, fn_w[4]); end
    mem_we = 1'b0;
    do_reset();
    pc = 32'h10; tick();
    pc = 32'h44; gp = 32'd1; tick();
    n_checks++; if ({pass_w[4], fail_w[4]} !== 2'b10) begin n_fail++;
      $display("FAIL m2_pc_only pass,fail=%b exp=10", {pass_w[4], fail_w[4]}); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    for (int i = 0; i < 5; i++) begin pc = 32'h400 + 32'(i * 4); tick(); end
    n_checks++; if (cy_w[0] !== 32'd5) begin n_fail++; $display("FAIL mid_cycles_before got=%0d exp=5", cy_w[0]); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (cy_w[0] !== 32'd0 || done_w[0] !== 1'b0) begin n_fail++;
      $display("FAIL mid_run_reset cycles=%0d done=%b exp 0 0", cy_w[0], done_w[0]); end
    @(negedge clk); rst = 1'b0; tick();
    for (int i = 0; i < 3; i++) begin pc = 32'h500 + 32'(i * 4); tick(); end
    n_checks++; if (cy_w[0] !== 32'd3) begin n_fail++; $display("FAIL mid_restart_cycles got=%0d exp=3", cy_w[0]); end
    pc = 32'h44; gp = 32'd1; tick();
    n_checks++; if (pass_w[0] !== 1'b1) begin n_fail++; $display("FAIL mid_pass got=%b exp=1", pass_w[0]); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({done_w[0], pass_w[0]} !== 2'b00 || cy_w[0] !== 32'd0) begin n_fail++;
      $display("FAIL pass_reset done,pass=%b cycles=%0d exp 00 0", {done_w[0], pass_w[0]}, cy_w[0]); end
    @(negedge clk); rst = 1'b0; pc = 32'h600; tick();
    tick();
    n_checks++; if (cy_w[0] !== 32'd1 || pass_w[0] !== 1'b0) begin n_fail++;
      $display("FAIL post_reset_run cycles=%0d pass=%b exp 1 0", cy_w[0], pass_w[0]); end
  endtask

  initial begin
    test_reset();
    test_mode0_pass();
    test_mode0_fail();
    test_tohost();
    test_timeout();
    test_hang();
    test_mode2();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
